interrupt_controller: RTL

INTERRUPT_CONTROLLER -- requirements
Module: interrupt_controller

---
 rtl/interrupt_controller.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/interrupt_controller.sv
// ---------------------------------------------------------------------------
// interrupt_controller
//
// Prioritised interrupt controller with one non-maskable line.
// Rising edges on irq_in/nmi_in latch into pending flags. The lowest-indexed
// pending, unmasked source is offered to the CPU through INT. The CPU answers
// with inta, which captures that source. INTD and vector are then presented
// for exactly one cycle. The controller waits in service until eoi arrives.
// NMI is independent of the maskable path and is cleared by nmi_ack.
//
// Handshake: INT is high only in REQ. inta is honoured only in REQ, and the
// winner is frozen on that same edge. INTD/vector are valid for the single
// VEC cycle. eoi is honoured only in SERV. Pulses that arrive outside those
// windows are ignored.
//
// Ports
//   clk       in   clock, rising edge
//   reset     in   synchronous, active-low
//   irq_in    in   [NSRC] device request lines (rising-edge sensitive)
//   nmi_in    in   non-maskable request (rising-edge sensitive)
//   mask_we   in   mask register write strobe
//   mask_wd   in   [NSRC] mask data, 1 = source disabled
//   ie        in   global maskable-interrupt enable
//   inta      in   INT acknowledge pulse
//   eoi       in   end-of-interrupt pulse
//   nmi_ack   in   NMI acknowledge pulse
//   INT       out  maskable interrupt request
//   INTD      out  vector-valid strobe (one cycle)
//   NMI       out  non-maskable request
//   vector    out  [32] VEC_BASE + 4*index while INTD, else 0
//   pending   out  [NSRC] pending flags
//   o_state   out  [2] FSM state for debug (0 IDLE, 1 REQ, 2 VEC, 3 SERV)
// ---------------------------------------------------------------------------
module interrupt_controller #(
    parameter int          NSRC     = 8,
    parameter logic [31:0] VEC_BASE = 32'h0000_0080
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NSRC-1:0] irq_in,
    input  logic            nmi_in,
    input  logic            mask_we,
    input  logic [NSRC-1:0] mask_wd,
    input  logic            ie,
    input  logic            inta,
    input  logic            eoi,
    input  logic            nmi_ack,
    output logic            INT,
    output logic            INTD,
    output logic            NMI,
    output logic [31:0]     vector,
    output logic [NSRC-1:0] pending,
    output logic [1:0]      o_state
);

    localparam int IDXW = (NSRC > 1) ? $clog2(NSRC) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_VEC  = 2'd2,
        S_SERV = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic [NSRC-1:0]   r_irq_d;
    logic [NSRC-1:0]   r_pend;
    logic [NSRC-1:0]   r_mask;
    logic              r_nmi_d;
    logic              r_nmi_pend;
    logic [IDXW-1:0]   r_idx;

    logic [NSRC-1:0]   w_irq_rise;
    logic [NSRC-1:0]   w_elig;
    logic [NSRC-1:0]   w_clr;
    logic [NSRC-1:0]   w_pend_nxt;
    logic              w_any_elig;
    logic              w_nmi_rise;
    logic              w_capture;
    logic [IDXW-1:0]   w_win_idx;

    assign w_irq_rise = irq_in & ~r_irq_d;
    assign w_nmi_rise = nmi_in & ~r_nmi_d;
    assign w_elig     = r_pend & ~r_mask;
    assign w_any_elig = |w_elig;

    // Lowest eligible index wins. Scanning downward lets the last hit be
    // the smallest index.
    always_comb begin
        w_win_idx = '0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (w_elig[i]) begin
                w_win_idx = IDXW'(i);
            end
        end
    end

    // The captured source is retired during VEC. A new edge in that same
    // cycle is ORed in after the clear, so the new request survives.
    assign w_clr      = (r_state == S_VEC) ? (NSRC'(1) << r_idx) : '0;
    assign w_pend_nxt = (r_pend & ~w_clr) | w_irq_rise;

    // FSM state register
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state and Moore outputs
    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        INT         = 1'b0;
        INTD        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (ie && w_any_elig) begin
                    w_state_nxt = S_REQ;
                end
            end
            S_REQ: begin
                INT = 1'b1;
                // Withdrawal takes precedence over an acknowledge. This
                // keeps a valid winner available whenever inta is honoured.
                if (!ie || !w_any_elig) begin
                    w_state_nxt = S_IDLE;
                end else if (inta) begin
                    w_state_nxt = S_VEC;
                    w_capture   = 1'b1;
                end
            end
            S_VEC: begin
                INTD        = 1'b1;
                w_state_nxt = S_SERV;
            end
            S_SERV: begin
                if (eoi) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Edge detectors, pending flags, mask and the captured index.
    // r_idx also serves as the in-service index until the next capture.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_irq_d    <= '0;
            r_pend     <= '0;
            r_mask     <= '1;
            r_nmi_d    <= 1'b0;
            r_nmi_pend <= 1'b0;
            r_idx      <= '0;
        end else begin
            r_irq_d    <= irq_in;
            r_pend     <= w_pend_nxt;
            r_nmi_d    <= nmi_in;
            r_nmi_pend <= (r_nmi_pend & ~nmi_ack) | w_nmi_rise;
            if (mask_we) begin
                r_mask <= mask_wd;
            end
            if (w_capture) begin
                r_idx <= w_win_idx;
            end
        end
    end

    assign NMI     = r_nmi_pend;
    assign pending = r_pend;
    assign vector  = INTD ? (VEC_BASE + (32'(r_idx) << 2)) : 32'd0;
    assign o_state = r_state;

endmodule
